// File: rtl/mel_frame_sequencer.sv
// Mel frame sequencer: streams power-spectrum bins one frame at a time into the mel filterbank.
// Latency: one registered cycle from an accepted bin to mf_di_en/mf_data/mf_* tags.
// Backpressure: s_ready is high only in RUN; it stays low while a frame result is outstanding.
module mel_frame_sequencer #(
  parameter int I_BW       = 14,
  parameter int N_BINS     = 513,
  parameter int MAX_FRAMES = 89,
  parameter int FRAME_W    = 7,
  parameter int BIN_W      = 10,
  parameter int TIMEOUT    = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [FRAME_W:0]       num_frames,
  input  logic                   s_valid,
  input  logic signed [I_BW-1:0] s_data,
  output logic                   s_ready,
  output logic signed [I_BW-1:0] mf_data,
  output logic                   mf_di_en,
  output logic [BIN_W-1:0]       mf_bin_idx,
  output logic [FRAME_W-1:0]     mf_frame_idx,
  output logic                   mf_first,
  output logic                   mf_last,
  input  logic                   mf_do_en,
  input  logic [FRAME_W-1:0]     mf_out_frame,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_OUT} state_t;

  localparam int                WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [BIN_W-1:0]  LAST_BIN = BIN_W'(N_BINS - 1);
  localparam logic [FRAME_W:0]  MAX_NF   = (FRAME_W + 1)'(MAX_FRAMES);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);

  state_t           state;
  logic [BIN_W-1:0] bin_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic [FRAME_W:0] nf_q;
  logic [WD_W-1:0]  wdog;
  logic             xfer;
  logic             last_frame;

  // A bin is taken only while streaming; abort blocks a same-cycle transfer so nothing is half-sent.
  assign s_ready    = (state == RUN) && !abort;
  assign xfer       = s_valid && s_ready;
  assign busy       = (state != IDLE);
  assign last_frame = (({1'b0, frame_cnt} + 1'b1) == nf_q);

  // Control FSM with all filterbank-facing and status outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bin_cnt      <= '0;
      frame_cnt    <= '0;
      nf_q         <= '0;
      wdog         <= '0;
      mf_data      <= '0;
      mf_di_en     <= 1'b0;
      mf_bin_idx   <= '0;
      mf_frame_idx <= '0;
      mf_first     <= 1'b0;
      mf_last      <= 1'b0;
      frame_done   <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      mf_di_en   <= 1'b0;
      frame_done <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        // abort drops the run without pulses and leaves err as it was
        state     <= IDLE;
        bin_cnt   <= '0;
        frame_cnt <= '0;
        wdog      <= '0;
      end else begin
        // a filterbank result with no frame outstanding is a protocol error
        if (mf_do_en && (state != WAIT_OUT)) err <= 1'b1;
        case (state)
          IDLE: begin
            if (start) begin
              if (num_frames == '0) begin
                err <= 1'b1;
              end else begin
                state     <= RUN;
                bin_cnt   <= '0;
                frame_cnt <= '0;
                wdog      <= '0;
                if (num_frames > MAX_NF) begin
                  nf_q <= MAX_NF;
                  err  <= 1'b1;
                end else begin
                  nf_q <= num_frames;
                  // start clears err, but a stray result in the same cycle still counts
                  err  <= mf_do_en;
                end
              end
            end
          end
          RUN: begin
            if (xfer) begin
              mf_di_en     <= 1'b1;
              mf_data      <= s_data;
              mf_bin_idx   <= bin_cnt;
              mf_frame_idx <= frame_cnt;
              mf_first     <= (bin_cnt == '0);
              mf_last      <= (bin_cnt == LAST_BIN);
              if (bin_cnt == LAST_BIN) begin
                bin_cnt <= '0;
                wdog    <= '0;
                state   <= WAIT_OUT;
              end else begin
                bin_cnt <= bin_cnt + 1'b1;
              end
            end
          end
          WAIT_OUT: begin
            if (mf_do_en) begin
              // a mismatched frame tag is flagged but the sequence carries on
              if (mf_out_frame != frame_cnt) err <= 1'b1;
              frame_done <= 1'b1;
              wdog       <= '0;
              if (last_frame) begin
                done      <= 1'b1;
                frame_cnt <= '0;
                state     <= IDLE;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
                state     <= RUN;
              end
            end else if (wdog == WD_LAST) begin
              err       <= 1'b1;
              frame_cnt <= '0;
              wdog      <= '0;
              state     <= IDLE;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
